calendar_date_counter: RTL and testbench

//  Parametrised day/month/year counter for the century clock: successor to the fixed
//  day counter. Advances or retreats one calendar day per tick. Applies the full

---
 rtl/calendar_date_counter.sv | 121 ++++++++++++
 tb/tb_calendar_date_counter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/calendar_date_counter.sv
// Day/month/year calendar counter with Gregorian leap rule, validated parallel load
// and registered month/year/wrap pulses; counts one day per tick in either direction.
module calendar_date_counter #(
  parameter int YEAR_W    = 8,
  parameter int YEAR_MAX  = 199,
  parameter int BASE_YEAR = 2000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              dir,
  input  logic              load,
  input  logic [4:0]        load_day,
  input  logic [3:0]        load_mon,
  input  logic [YEAR_W-1:0] load_year,
  output logic [4:0]        day,
  output logic [3:0]        mon,
  output logic [YEAR_W-1:0] year,
  output logic              leap,
  output logic [4:0]        dim,
  output logic              pulse_mon,
  output logic              pulse_year,
  output logic              pulse_wrap,
  output logic              load_err
);

  localparam int YEARS = 1 << YEAR_W;
  localparam logic [YEAR_W-1:0] YMAX = YEAR_W'(YEAR_MAX);

  // Leap flags are fixed by BASE_YEAR, so they fold into a constant table.
  logic [YEARS-1:0] leap_tab;
  generate
    for (genvar gi = 0; gi < YEARS; gi++) begin : g_leap
      localparam int Y = BASE_YEAR + gi;
      assign leap_tab[gi] = (((Y % 4) == 0) && (((Y % 100) != 0) || ((Y % 400) == 0))) ? 1'b1 : 1'b0;
    end
  endgenerate

  function automatic logic [4:0] dim_of(input logic [3:0] m, input logic lp);
    case (m)
      4'd2:                      dim_of = lp ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:   dim_of = 5'd30;
      default:                   dim_of = 5'd31;
    endcase
  endfunction

  logic              load_ok;
  logic [YEAR_W-1:0] next_year;
  logic [YEAR_W-1:0] prev_year;
  logic [3:0]        back_mon;
  logic [YEAR_W-1:0] back_year;
  logic [4:0]        back_day;

  assign leap = leap_tab[year];
  assign dim  = dim_of(mon, leap);

  // The day bound uses the leap flag of the year being loaded, not the current one.
  assign load_ok = (load_mon >= 4'd1) && (load_mon <= 4'd12) && (load_year <= YMAX) &&
                   (load_day != 5'd0) && (load_day <= dim_of(load_mon, leap_tab[load_year]));

  assign next_year = (year == YMAX) ? '0 : year + 1'b1;
  assign prev_year = (year == '0) ? YMAX : year - 1'b1;
  assign back_mon  = (mon == 4'd1) ? 4'd12 : mon - 4'd1;
  assign back_year = (mon == 4'd1) ? prev_year : year;
  assign back_day  = dim_of(back_mon, leap_tab[back_year]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      day        <= 5'd1;
      mon        <= 4'd1;
      year       <= '0;
      pulse_mon  <= 1'b0;
      pulse_year <= 1'b0;
      pulse_wrap <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      pulse_mon  <= 1'b0;
      pulse_year <= 1'b0;
      pulse_wrap <= 1'b0;
      load_err   <= 1'b0;
      if (load) begin
        if (load_ok) begin
          day  <= load_day;
          mon  <= load_mon;
          year <= load_year;
        end else begin
          load_err <= 1'b1;
        end
      end else if (tick) begin
        if (!dir) begin
          if (day < dim) begin
            day <= day + 5'd1;
          end else begin
            day       <= 5'd1;
            pulse_mon <= 1'b1;
            if (mon == 4'd12) begin
              mon        <= 4'd1;
              year       <= next_year;
              pulse_year <= 1'b1;
              pulse_wrap <= (year == YMAX);
            end else begin
              mon <= mon + 4'd1;
            end
          end
        end else begin
          if (day > 5'd1) begin
            day <= day - 5'd1;
          end else begin
            day        <= back_day;
            mon        <= back_mon;
            year       <= back_year;
            pulse_mon  <= 1'b1;
            pulse_year <= (mon == 4'd1);
            pulse_wrap <= (mon == 4'd1) && (year == '0);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_calendar_date_counter.sv
// Bench for calendar_date_counter: directed calendar scenarios with literal expectations,
// then randomized ticks/loads/resets checked every cycle against a date-arithmetic model.
module tb_calendar_date_counter;

  localparam int YEAR_W    = 8;
  localparam int YEAR_MAX  = 199;
  localparam int BASE_YEAR = 2000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              tick = 1'b0;
  logic              dir = 1'b0;
  logic              load = 1'b0;
  logic [4:0]        load_day = 5'd1;
  logic [3:0]        load_mon = 4'd1;
  logic [YEAR_W-1:0] load_year = '0;
  logic [4:0]        day;
  logic [3:0]        mon;
  logic [YEAR_W-1:0] year;
  logic              leap;
  logic [4:0]        dim;
  logic              pulse_mon, pulse_year, pulse_wrap, load_err;

  calendar_date_counter #(.YEAR_W(YEAR_W), .YEAR_MAX(YEAR_MAX), .BASE_YEAR(BASE_YEAR)) dut (
    .clk(clk), .rst(rst), .tick(tick), .dir(dir), .load(load),
    .load_day(load_day), .load_mon(load_mon), .load_year(load_year),
    .day(day), .mon(mon), .year(year), .leap(leap), .dim(dim),
    .pulse_mon(pulse_mon), .pulse_year(pulse_year), .pulse_wrap(pulse_wrap),
    .load_err(load_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Reference state
  int m_day = 1, m_mon = 1, m_year = 0;
  bit m_pm = 0, m_py = 0, m_pw = 0, m_err = 0;

  function automatic bit is_leap(int y);
    return (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
  endfunction

  function automatic int mdim(int m, int yoff);
    int t[12];
    t = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (m < 1 || m > 12) return 0;
    if (m == 2 && is_leap(BASE_YEAR + yoff)) return 29;
    return t[m-1];
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic m_reset();
    m_day = 1; m_mon = 1; m_year = 0;
    m_pm = 0; m_py = 0; m_pw = 0; m_err = 0;
  endtask

  // Applies the calendar rules to the inputs sampled at this edge.
  task automatic model_update();
    int ld, lm, ly;
    if (rst) begin
      m_reset();
      return;
    end
    m_pm = 0; m_py = 0; m_pw = 0; m_err = 0;
    if (load) begin
      ld = int'(load_day); lm = int'(load_mon); ly = int'(load_year);
      if (lm >= 1 && lm <= 12 && ly <= YEAR_MAX && ld >= 1 && ld <= mdim(lm, ly)) begin
        m_day = ld; m_mon = lm; m_year = ly;
      end else begin
        m_err = 1;
      end
    end else if (tick) begin
      if (!dir) begin
        m_day++;
        if (m_day > mdim(m_mon, m_year)) begin
          m_day = 1; m_mon++; m_pm = 1;
          if (m_mon > 12) begin
            m_mon = 1; m_year++; m_py = 1;
            if (m_year > YEAR_MAX) begin m_year = 0; m_pw = 1; end
          end
        end
      end else begin
        m_day--;
        if (m_day < 1) begin
          m_mon--; m_pm = 1;
          if (m_mon < 1) begin
            m_mon = 12; m_year--; m_py = 1;
            if (m_year < 0) begin m_year = YEAR_MAX; m_pw = 1; end
          end
          m_day = mdim(m_mon, m_year);
        end
      end
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (check_en) begin
      chk("day", int'(day), m_day);
      chk("mon", int'(mon), m_mon);
      chk("year", int'(year), m_year);
      chk("leap", int'(leap), int'(is_leap(BASE_YEAR + m_year)));
      chk("dim", int'(dim), mdim(m_mon, m_year));
      chk("pulse_mon", int'(pulse_mon), int'(m_pm));
      chk("pulse_year", int'(pulse_year), int'(m_py));
      chk("pulse_wrap", int'(pulse_wrap), int'(m_pw));
      chk("load_err", int'(load_err), int'(m_err));
    end
  end

  task automatic cycle();
    @(posedge clk);
    model_update();
    #2;
  endtask

  task automatic do_load(int d, int m, int y, bit t);
    load = 1'b1; tick = t; dir = 1'b0;
    load_day = 5'(d); load_mon = 4'(m); load_year = YEAR_W'(y);
    cycle();
    load = 1'b0; tick = 1'b0;
  endtask

  task automatic do_tick(bit dr);
    tick = 1'b1; dir = dr;
    cycle();
    tick = 1'b0; dir = 1'b0;
  endtask

  task automatic lit_date(string name, int d, int m, int y);
    chk({name, "_day"}, int'(day), d);
    chk({name, "_mon"}, int'(mon), m);
    chk({name, "_year"}, int'(year), y);
  endtask

  task automatic lit_pulses(string name, int pm, int py, int pw);
    chk({name, "_pm"}, int'(pulse_mon), pm);
    chk({name, "_py"}, int'(pulse_year), py);
    chk({name, "_pw"}, int'(pulse_wrap), pw);
  endtask

  initial begin
    m_reset();
    cycle();
    check_en = 1'b1;
    rst = 1'b0;
    lit_date("reset", 1, 1, 0);
    cycle();

    // Async reset in the middle of a tick
    do_load(16, 8, 50, 0);
    do_tick(0);
    lit_date("run_to", 17, 8, 50);
    tick = 1'b1; rst = 1'b1; m_reset();
    #1;
    lit_date("async_rst", 1, 1, 0);
    lit_pulses("async_rst", 0, 0, 0);
    chk("async_rst_err", int'(load_err), 0);
    cycle();
    rst = 1'b0; tick = 1'b0;
    cycle();

    do_load(28, 2, 23, 0);
    do_tick(0);
    lit_date("feb23", 1, 3, 23);
    lit_pulses("feb23", 1, 0, 0);
    cycle();
    chk("feb23_pm_clear", int'(pulse_mon), 0);
    do_load(28, 2, 24, 0);
    do_tick(0);
    lit_date("feb24", 29, 2, 24);
    chk("feb24_pm", int'(pulse_mon), 0);

    do_load(28, 2, 100, 0);
    do_tick(0);
    lit_date("y2100", 1, 3, 100);
    chk("y2100_leap", int'(leap), 0);
    do_load(28, 2, 0, 0);
    do_tick(0);
    lit_date("y2000", 29, 2, 0);
    chk("y2000_leap", int'(leap), 1);
    chk("y2000_dim", int'(dim), 29);

    do_load(31, 12, 199, 0);
    do_tick(0);
    lit_date("wrap_up", 1, 1, 0);
    lit_pulses("wrap_up", 1, 1, 1);
    cycle();
    lit_pulses("wrap_up_clr", 0, 0, 0);

    do_load(1, 3, 24, 0);
    do_tick(1);
    lit_date("down_feb", 29, 2, 24);
    lit_pulses("down_feb", 1, 0, 0);
    do_load(1, 1, 0, 0);
    do_tick(1);
    lit_date("wrap_dn", 31, 12, 199);
    lit_pulses("wrap_dn", 1, 1, 1);

    do_load(15, 6, 50, 0);
    do_load(30, 2, 24, 0);
    chk("bad_load_err", int'(load_err), 1);
    lit_date("bad_load", 15, 6, 50);
    cycle();
    chk("bad_load_err_clr", int'(load_err), 0);
    do_load(31, 12, 10, 0);
    do_load(15, 6, 50, 1);
    lit_date("load_tick", 15, 6, 50);
    lit_pulses("load_tick", 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = int'($urandom_range(0, 999));
      if (r < 3) begin
        rst = 1'b1; m_reset();
        cycle();
        rst = 1'b0;
      end else begin
        tick = ($urandom_range(0, 99) < 70);
        dir  = ($urandom_range(0, 3) == 0) ? ~dir : dir;
        load = ($urandom_range(0, 99) < 8);
        load_day  = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(26, 31)) : 5'($urandom_range(0, 31));
        load_mon  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(11, 12)) : 4'($urandom_range(0, 15));
        case ($urandom_range(0, 3))
          0:       load_year = YEAR_W'(YEAR_MAX);
          1:       load_year = '0;
          default: load_year = YEAR_W'($urandom_range(0, 255));
        endcase
        cycle();
        load = 1'b0;
      end
    end
    tick = 1'b0; load = 1'b0;
    cycle();
    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
